// File: rtl/dsp_pkg.sv
// Shared constants and sizing helpers for the DSP48A1 datapath blocks.
package dsp_pkg;

    typedef enum logic {
        RST_SYNC  = 1'b0,
        RST_ASYNC = 1'b1
    } rst_type_e;

    localparam rst_type_e DSP_RST_TYPE = RST_ASYNC;

    localparam int DSP_A_W = 18;
    localparam int DSP_B_W = 18;
    localparam int DSP_C_W = 48;
    localparam int DSP_D_W = 18;
    localparam int DSP_M_W = 36;
    localparam int DSP_P_W = 48;

    // Width of a counter that must hold 0..depth, never narrower than 1.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_chain_if.sv
// Input/output valid-ready handshake bundle for a DSP pipeline chain.
interface dsp_pipe_chain_if
    import dsp_pkg::*;
#(
    parameter int WIDTH = DSP_A_W
);
    logic [WIDTH-1:0] IN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT;
    logic             OUT_VALID;
    logic             OUT_READY;

    modport master (
        output IN, IN_VALID, OUT_READY,
        input  IN_READY, OUT, OUT_VALID
    );

    modport slave (
        input  IN, IN_VALID, OUT_READY,
        output IN_READY, OUT, OUT_VALID
    );
endinterface

// File: rtl/dsp_pipe_stage.sv
// One data+valid register of the pipeline chain.
module dsp_pipe_stage
    import dsp_pkg::*;
#(
    parameter int               WIDTH   = DSP_A_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Data only moves with a valid sample, so a bubble never overwrites it.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (ld_i) begin
            valid_d = valid_i;
            if (valid_i) data_d = data_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dsp_pipe_chain.sv
// Elastic 0..N stage register chain with backpressure, flush and occupancy.
module dsp_pipe_chain
    import dsp_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              OW      = occ_w(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CE,
    input  logic                   FLUSH,
    dsp_pipe_chain_if.slave        bus,
    output logic [OW-1:0]          OCCUPANCY
);

    logic en;
    assign en = CE & ~FLUSH;

    if (DEPTH == 0) begin : g_bypass
        assign bus.OUT       = bus.IN;
        assign bus.OUT_VALID = bus.IN_VALID & en;
        assign bus.IN_READY  = bus.OUT_READY & en;
        assign OCCUPANCY     = '0;
    end else begin : g_chain
        logic [WIDTH-1:0] data [DEPTH];
        logic [DEPTH-1:0] vld;
        logic [DEPTH-1:0] rdy;
        logic [OW-1:0]    occ_q, occ_d;
        logic             in_xfer, out_xfer;

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] up_data;
            logic             up_vld;

            // Unrolled ready chain: stalls only if every stage downstream is full.
            assign rdy[i] = bus.OUT_READY | ~(&vld[DEPTH-1:i]);

            if (i == 0) begin : g_head
                assign up_data = bus.IN;
                assign up_vld  = bus.IN_VALID;
            end else begin : g_body
                assign up_data = data[i-1];
                assign up_vld  = vld[i-1];
            end

            dsp_pipe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .CLK     (CLK),
                .RST     (RST),
                .ld_i    (en & rdy[i]),
                .clr_i   (FLUSH),
                .data_i  (up_data),
                .valid_i (up_vld),
                .data_o  (data[i]),
                .valid_o (vld[i])
            );
        end

        assign bus.IN_READY  = rdy[0] & en;
        assign bus.OUT_VALID = vld[DEPTH-1] & en;
        assign bus.OUT       = data[DEPTH-1];

        assign in_xfer  = bus.IN_VALID & bus.IN_READY;
        assign out_xfer = bus.OUT_VALID & bus.OUT_READY;

        always_comb begin
            occ_d = occ_q;
            unique case (1'b1)
                FLUSH:                occ_d = '0;
                in_xfer & ~out_xfer:  occ_d = occ_q + OW'(1);
                out_xfer & ~in_xfer:  occ_d = occ_q - OW'(1);
                default:              ;
            endcase
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) occ_q <= '0;
            else     occ_q <= occ_d;
        end

        assign OCCUPANCY = occ_q;
    end

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// Directed bench: DEPTH=3 chain with all-ones reset value and a DEPTH=0 bypass.
module tb_dsp_pipe_chain;
    import dsp_pkg::*;

    localparam int             W   = 18;
    localparam int             OW3 = occ_w(3);
    localparam int             OW0 = occ_w(0);
    localparam logic [W-1:0]   RV  = 18'h3FFFF;

    logic           CLK = 1'b0;
    logic           RST;
    logic           ce3, fl3, ce0, fl0;
    logic [OW3-1:0] occ3;
    logic [OW0-1:0] occ0;
    int             n_cmp = 0;
    int             n_bad = 0;

    dsp_pipe_chain_if #(.WIDTH(W)) b3 ();
    dsp_pipe_chain_if #(.WIDTH(W)) b0 ();

    always #5 CLK = ~CLK;

    dsp_pipe_chain #(.WIDTH(W), .DEPTH(3), .RST_VAL(RV)) u_d3 (
        .CLK(CLK), .RST(RST), .CE(ce3), .FLUSH(fl3),
        .bus(b3), .OCCUPANCY(occ3)
    );

    dsp_pipe_chain #(.WIDTH(W), .DEPTH(0), .RST_VAL('0)) u_d0 (
        .CLK(CLK), .RST(RST), .CE(ce0), .FLUSH(fl0),
        .bus(b0), .OCCUPANCY(occ0)
    );

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if (b3.OUT !== RV) begin
            n_bad++; $display("FAIL rst_out: got %h want %h", b3.OUT, RV);
        end
        n_cmp++;
        if (b3.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL rst_ovalid: got %b want 0", b3.OUT_VALID);
        end
        n_cmp++;
        if (occ3 !== 2'd0) begin
            n_bad++; $display("FAIL rst_occ: got %0d want 0", occ3);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (b3.IN_READY !== 1'b1) begin
            n_bad++; $display("FAIL rst_iready: got %b want 1", b3.IN_READY);
        end
        b3.IN = 18'd5; b3.IN_VALID = 1'b1; tick();
        b3.IN = 18'd6; tick();
        b3.IN = 18'd7; tick();
        b3.IN_VALID = 1'b0;
        #1;
        n_cmp++;
        if (b3.OUT !== 18'd5 || b3.OUT_VALID !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst_out: got %h/%b want 5/1", b3.OUT, b3.OUT_VALID);
        end
        n_cmp++;
        if (occ3 !== 2'd3 || b3.IN_READY !== 1'b0) begin
            n_bad++; $display("FAIL pre_rst_full: got occ %0d rdy %b want 3/0", occ3, b3.IN_READY);
        end
        RST = 1'b1;
        #1;
        n_cmp++;
        if (b3.OUT !== RV || b3.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_out: got %h/%b want %h/0", b3.OUT, b3.OUT_VALID, RV);
        end
        n_cmp++;
        if (occ3 !== 2'd0) begin
            n_bad++; $display("FAIL mid_rst_occ: got %0d want 0", occ3);
        end
        tick();
        RST = 1'b0;
        #1;
        n_cmp++;
        if (b3.IN_READY !== 1'b1) begin
            n_bad++; $display("FAIL post_rst_iready: got %b want 1", b3.IN_READY);
        end
    endtask

    task automatic test_stream();
        int          occ_e [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
        logic        ov_e  [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        int          out_e [8] = '{0, 0, 1, 2, 3, 4, 4, 4};
        b3.OUT_READY = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            b3.IN       = (e <= 4) ? W'(e) : '0;
            b3.IN_VALID = (e <= 4);
            if (e <= 4) begin
                #1;
                n_cmp++;
                if (b3.IN_READY !== 1'b1) begin
                    n_bad++; $display("FAIL stream_iready[%0d]: got %b want 1", e, b3.IN_READY);
                end
            end
            tick();
            n_cmp++;
            if (b3.OUT_VALID !== ov_e[e-1]) begin
                n_bad++; $display("FAIL stream_ovalid[%0d]: got %b want %b", e, b3.OUT_VALID, ov_e[e-1]);
            end
            if (e >= 3) begin
                n_cmp++;
                if (b3.OUT !== W'(out_e[e-1])) begin
                    n_bad++; $display("FAIL stream_out[%0d]: got %0d want %0d", e, b3.OUT, out_e[e-1]);
                end
            end
            n_cmp++;
            if (occ3 !== OW3'(occ_e[e-1])) begin
                n_bad++; $display("FAIL stream_occ[%0d]: got %0d want %0d", e, occ3, occ_e[e-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_o [4] = '{10, 20, 30, 40};
        int exp_c [4] = '{3, 2, 1, 0};
        b3.OUT_READY = 1'b0;
        b3.IN = 18'd10; b3.IN_VALID = 1'b1; tick();
        b3.IN_VALID = 1'b0; tick();
        n_cmp++;
        if (occ3 !== 2'd1) begin
            n_bad++; $display("FAIL bp_occ_bubble: got %0d want 1", occ3);
        end
        b3.IN = 18'd20; b3.IN_VALID = 1'b1; tick();
        n_cmp++;
        if (occ3 !== 2'd2) begin
            n_bad++; $display("FAIL bp_occ_20: got %0d want 2", occ3);
        end
        b3.IN = 18'd30; tick();
        b3.IN = 18'd40;
        #1;
        n_cmp++;
        if (occ3 !== 2'd3 || b3.IN_READY !== 1'b0) begin
            n_bad++; $display("FAIL bp_full: got occ %0d rdy %b want 3/0", occ3, b3.IN_READY);
        end
        n_cmp++;
        if (b3.OUT !== 18'd10 || b3.OUT_VALID !== 1'b1) begin
            n_bad++; $display("FAIL bp_head: got %0d/%b want 10/1", b3.OUT, b3.OUT_VALID);
        end
        tick();
        tick();
        n_cmp++;
        if (occ3 !== 2'd3 || b3.IN_READY !== 1'b0 || b3.OUT !== 18'd10) begin
            n_bad++; $display("FAIL bp_hold: got occ %0d rdy %b out %0d want 3/0/10", occ3, b3.IN_READY, b3.OUT);
        end
        b3.OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (b3.OUT_VALID !== 1'b1 || b3.OUT !== W'(exp_o[i])) begin
                n_bad++; $display("FAIL bp_drain_out[%0d]: got %0d/%b want %0d/1", i, b3.OUT, b3.OUT_VALID, exp_o[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (b3.IN_READY !== 1'b1) begin
                    n_bad++; $display("FAIL bp_release_rdy: got %b want 1", b3.IN_READY);
                end
            end
            tick();
            if (i == 0) b3.IN_VALID = 1'b0;
            n_cmp++;
            if (occ3 !== OW3'(exp_c[i])) begin
                n_bad++; $display("FAIL bp_drain_occ[%0d]: got %0d want %0d", i, occ3, exp_c[i]);
            end
        end
        #1;
        n_cmp++;
        if (b3.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL bp_empty: got %b want 0", b3.OUT_VALID);
        end
    endtask

    task automatic test_ce();
        b3.OUT_READY = 1'b0;
        b3.IN = 18'd70; b3.IN_VALID = 1'b1; tick();
        b3.IN = 18'd71; tick();
        ce3 = 1'b0;
        b3.IN = 18'd72;
        #1;
        n_cmp++;
        if (b3.IN_READY !== 1'b0 || b3.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL ce_gate: got rdy %b ov %b want 0/0", b3.IN_READY, b3.OUT_VALID);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (occ3 !== 2'd2 || b3.OUT !== 18'd40 || b3.IN_READY !== 1'b0 || b3.OUT_VALID !== 1'b0) begin
                n_bad++; $display("FAIL ce_hold[%0d]: got occ %0d out %0d rdy %b ov %b want 2/40/0/0", k, occ3, b3.OUT, b3.IN_READY, b3.OUT_VALID);
            end
        end
        ce3 = 1'b1;
        b3.IN_VALID = 1'b0;
        b3.OUT_READY = 1'b1;
        tick();
        n_cmp++;
        if (b3.OUT !== 18'd70 || b3.OUT_VALID !== 1'b1 || occ3 !== 2'd2) begin
            n_bad++; $display("FAIL ce_resume1: got %0d/%b occ %0d want 70/1/2", b3.OUT, b3.OUT_VALID, occ3);
        end
        tick();
        n_cmp++;
        if (b3.OUT !== 18'd71 || b3.OUT_VALID !== 1'b1 || occ3 !== 2'd1) begin
            n_bad++; $display("FAIL ce_resume2: got %0d/%b occ %0d want 71/1/1", b3.OUT, b3.OUT_VALID, occ3);
        end
        tick();
        n_cmp++;
        if (b3.OUT_VALID !== 1'b0 || occ3 !== 2'd0) begin
            n_bad++; $display("FAIL ce_resume3: got ov %b occ %0d want 0/0", b3.OUT_VALID, occ3);
        end
    endtask

    task automatic test_flush();
        b3.OUT_READY = 1'b0;
        b3.IN = 18'd80; b3.IN_VALID = 1'b1; tick();
        b3.IN = 18'd81; tick();
        n_cmp++;
        if (occ3 !== 2'd2) begin
            n_bad++; $display("FAIL fl_pre_occ: got %0d want 2", occ3);
        end
        b3.IN = 18'd55;
        b3.OUT_READY = 1'b1;
        fl3 = 1'b1;
        #1;
        n_cmp++;
        if (b3.IN_READY !== 1'b0 || b3.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL fl_gate: got rdy %b ov %b want 0/0", b3.IN_READY, b3.OUT_VALID);
        end
        tick();
        fl3 = 1'b0;
        b3.IN_VALID = 1'b0;
        #1;
        n_cmp++;
        if (occ3 !== 2'd0 || b3.OUT_VALID !== 1'b0 || b3.OUT !== 18'd71) begin
            n_bad++; $display("FAIL fl_after: got occ %0d ov %b out %0d want 0/0/71", occ3, b3.OUT_VALID, b3.OUT);
        end
        n_cmp++;
        if (b3.IN_READY !== 1'b1) begin
            n_bad++; $display("FAIL fl_rdy: got %b want 1", b3.IN_READY);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (occ3 !== 2'd0 || b3.OUT_VALID !== 1'b0 || b3.OUT !== 18'd71) begin
            n_bad++; $display("FAIL fl_settle: got occ %0d ov %b out %0d want 0/0/71", occ3, b3.OUT_VALID, b3.OUT);
        end
    endtask

    task automatic test_passthrough();
        logic r;
        b0.IN = 18'h01234;
        b0.IN_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r = k[0];
            b0.OUT_READY = r;
            #1;
            n_cmp++;
            if (b0.OUT !== 18'h01234 || b0.OUT_VALID !== 1'b1) begin
                n_bad++; $display("FAIL pt_out[%0d]: got %h/%b want 01234/1", k, b0.OUT, b0.OUT_VALID);
            end
            n_cmp++;
            if (b0.IN_READY !== r || occ0 !== 1'b0) begin
                n_bad++; $display("FAIL pt_rdy[%0d]: got rdy %b occ %0d want %b/0", k, b0.IN_READY, occ0, r);
            end
        end
        ce0 = 1'b0;
        #1;
        n_cmp++;
        if (b0.IN_READY !== 1'b0 || b0.OUT_VALID !== 1'b0 || b0.OUT !== 18'h01234) begin
            n_bad++; $display("FAIL pt_ce: got rdy %b ov %b out %h want 0/0/01234", b0.IN_READY, b0.OUT_VALID, b0.OUT);
        end
        ce0 = 1'b1;
        fl0 = 1'b1;
        #1;
        n_cmp++;
        if (b0.IN_READY !== 1'b0 || b0.OUT_VALID !== 1'b0) begin
            n_bad++; $display("FAIL pt_flush: got rdy %b ov %b want 0/0", b0.IN_READY, b0.OUT_VALID);
        end
        fl0 = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        ce3 = 1'b1; fl3 = 1'b0;
        ce0 = 1'b1; fl0 = 1'b0;
        b3.IN = '0; b3.IN_VALID = 1'b0; b3.OUT_READY = 1'b0;
        b0.IN = '0; b0.IN_VALID = 1'b0; b0.OUT_READY = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_ce();
        test_flush();
        test_passthrough();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_pipe_chain.md
Name: dsp_pipe_chain

Overview:
Parametrised pipeline register chain for the DSP48A1 datapath (A/B/C/D/M/P paths).
- Generalises the single optional register stage to 0..N stages.
- Adds per-stage valid tracking, valid/ready backpressure with bubble collapse, a synchronous flush and an occupancy count.
- Sits between the input port registers and the pre-adder/multiplier/post-adder, so variable-latency consumers can stall the datapath without losing samples.

Parameters:
- WIDTH, 18, data width of each stage.
- DEPTH, 2, number of register stages; 0 = combinational passthrough.
- RST_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CE  in  1  global clock enable; no transfers and no state change when low.
- FLUSH  in  1  synchronous clear of all stage valids.
- IN  in  WIDTH  input data.
- IN_VALID  in  1  input data valid.
- IN_READY  out  1  chain accepts input this cycle.
- OUT  out  WIDTH  last-stage data.
- OUT_VALID  out  1  last-stage data valid.
- OUT_READY  in  1  consumer accepts output.
- OCCUPANCY  out  max(1,$clog2(DEPTH+1))  number of valid stages.

Behaviour:
- Reset (async, immediate on RST=1, including mid-operation):
  - All stage valids = 0.
  - All data registers = RST_VAL.
  - OCCUPANCY = 0.
  - OUT = RST_VAL, OUT_VALID = 0.
- Per stage i (0 = input side, DEPTH-1 = output side):
  - ready_i = ~valid_i | ready_{i+1}.
  - ready_DEPTH = OUT_READY.
- Outputs:
  - IN_READY = ready_0 & CE & ~FLUSH.
  - OUT_VALID = valid_{DEPTH-1} & CE & ~FLUSH.
  - OUT = data_{DEPTH-1}, held when OUT_VALID=0.
- Transfer rules:
  - Input transfer = IN_VALID & IN_READY.
  - Output transfer = OUT_VALID & OUT_READY.
  - Both may occur in the same cycle.
- Stage update on CE=1, FLUSH=0:
  - Stage i loads data_{i-1}/valid_{i-1} (stage 0 loads IN/IN_VALID) when ready_i.
  - A stage whose upstream is invalid but which is itself draining becomes invalid.
  - Data registers load only when the incoming valid is 1; otherwise they hold.
- Bubble collapse: a stalled output does not block upstream stages that are empty. The chain accepts until all DEPTH stages are valid.
- Latency and throughput:
  - DEPTH cycles from input transfer to OUT_VALID when unstalled.
  - Throughput 1 sample/cycle.
  - Ordering preserved; no loss, no duplication.
- CE=0:
  - All registers hold, including OCCUPANCY.
  - IN_READY = 0, OUT_VALID = 0.
- FLUSH=1 (priority over CE and handshakes):
  - All valids clear at the next edge; data registers hold.
  - OCCUPANCY -> 0.
  - No input or output transfer occurs in the FLUSH cycle.
- OCCUPANCY update:
  - +1 on input-only transfer.
  - -1 on output-only transfer.
  - Unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- DEPTH=0:
  - No registers.
  - OUT = IN.
  - OUT_VALID = IN_VALID & CE & ~FLUSH.
  - IN_READY = OUT_READY & CE & ~FLUSH.
  - OCCUPANCY tied to 0.

Decomposition:
- Shared package dsp_pkg:
  - clog2-style width helper for OCCUPANCY.
  - Reset-type / default-width constants shared with the other DSP48A1 blocks.
- Sub-module dsp_pipe_stage:
  - One data+valid register with async RST, load enable and sync valid clear.
  - Instantiated DEPTH times in a generate loop.
  - Chain-level ready, OCCUPANCY and DEPTH=0 bypass stay in the top.

Test Plan:
1. Reset values: DEPTH=3, RST_VAL=18'h3FFFF, assert RST mid-stream → OUT=3FFFF, OUT_VALID=0, OCCUPANCY=0 in the same cycle; after release with CE=1, IN_READY=1.
2. Streaming latency: DEPTH=3, OUT_READY=1, inputs 1,2,3,4 back-to-back → OUT_VALID first rises 3 cycles after accepting 1; OUT = 1,2,3,4 on consecutive cycles; OCCUPANCY peaks at 3.
3. Backpressure and bubble collapse: DEPTH=3, OUT_READY=0, send 10, idle cycle, 20, 30, 40 → 10/20/30 accepted, IN_READY=0 at OCCUPANCY=3, 40 held; raise OUT_READY → outputs 10,20,30,40 in order, one transfer per cycle.
4. CE low: stall with OCCUPANCY=2 and drop CE for 4 cycles → IN_READY=0, OUT_VALID=0, registers and OCCUPANCY unchanged; restore CE → stream resumes with correct data.
5. FLUSH: OCCUPANCY=2 plus IN_VALID=1 with IN=55 in the FLUSH cycle → 55 not accepted, no output transfer; next cycle OCCUPANCY=0, OUT_VALID=0, OUT holds its last data.
6. DEPTH=0 passthrough: IN=0x1234, IN_VALID=1, OUT_READY toggling → OUT=0x1234 combinationally, IN_READY tracks OUT_READY; CE=0 forces IN_READY=0 and OUT_VALID=0.
